// File: rtl/zilla_loader_pkg.sv
// Shared definitions for the GPR UART loader: parser states, default frame header
// and the bytes-per-word helper.
package zilla_loader_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    IDX   = 3'd1,
    DATA  = 3'd2,
    CSUM  = 3'd3,
    WRITE = 3'd4
  } loader_state_t;

  localparam logic [7:0] FRAME_HDR_DEFAULT = 8'hA5;

  function automatic int nbytes(input int data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/loader_timeout_ctr.sv
// Inter-byte idle counter for the loader; flags expiry when the idle gap reaches
// TIMEOUT_CYCLES-1 while enabled.
module loader_timeout_ctr #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic reg_clk,
  input  logic reg_rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] TERM = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q;

  assign expired = enable && (cnt_q == TERM);

  always_ff @(posedge reg_clk or posedge reg_rst) begin
    if (reg_rst) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (enable && !expired) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

endmodule

// File: rtl/gpr_uart_loader.sv
// Parses header/index/little-endian data frames from a UART byte stream into single-cycle
// GPR writes. Define GPR_LOADER_CSUM_EN to require a trailing XOR checksum byte.
//
// state | meaning
// IDLE  | hunting for FRAME_HDR, other bytes dropped
// IDX   | expecting the register index byte
// DATA  | collecting NBYTES data bytes, LSB first
// CSUM  | expecting the XOR checksum byte (GPR_LOADER_CSUM_EN only)
// WRITE | strobe cycle, byte input stalled
module gpr_uart_loader
  import zilla_loader_pkg::*;
#(
  parameter int         DATA_WIDTH     = 32,
  parameter int         GPR_ADDR_WIDTH = 5,
  parameter logic [7:0] FRAME_HDR      = FRAME_HDR_DEFAULT,
  parameter int         TIMEOUT_CYCLES = 1024
) (
  input  logic                      reg_clk,
  input  logic                      reg_rst,
  input  logic [7:0]                rx_data_i,
  input  logic                      rx_valid_i,
  output logic                      rx_ready_o,
  output logic [GPR_ADDR_WIDTH-1:0] uart_rd,
  output logic                      uart_rd_valid,
  output logic [DATA_WIDTH-1:0]     uart_data,
  output logic                      busy_o,
  output logic                      frame_err_o,
  output logic [7:0]                load_cnt_o
);

  localparam int NBYTES = nbytes(DATA_WIDTH);
  localparam int BCW    = (NBYTES > 1) ? $clog2(NBYTES) : 1;
  localparam logic [BCW-1:0] LAST_BYTE = BCW'(NBYTES - 1);

  loader_state_t             state_q, state_d;
  logic [BCW-1:0]            bcnt_q;
  logic [GPR_ADDR_WIDTH-1:0] idx_q;
  logic [DATA_WIDTH-1:0]     shadow_q, shadow_d;
  logic                      accept, abort, finish, in_frame, expired;
`ifdef GPR_LOADER_CSUM_EN
  logic [7:0]                csum_q;
`endif

  assign rx_ready_o = (state_q != WRITE);
  assign busy_o     = (state_q != IDLE);
  assign accept     = rx_valid_i && rx_ready_o;
  assign in_frame   = (state_q == IDX) || (state_q == DATA) || (state_q == CSUM);

  loader_timeout_ctr #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .reg_clk(reg_clk),
    .reg_rst(reg_rst),
    .clear  (accept || !in_frame),
    .enable (in_frame),
    .expired(expired)
  );

  always_comb begin
    state_d  = state_q;
    abort    = 1'b0;
    finish   = 1'b0;
    shadow_d = shadow_q;
    case (state_q)
      IDLE: begin
        if (accept && (rx_data_i == FRAME_HDR)) state_d = IDX;
      end
      IDX: begin
        if (accept) begin
          if ((rx_data_i >> GPR_ADDR_WIDTH) != 8'd0) abort = 1'b1;
          else state_d = DATA;
        end else if (expired) begin
          abort = 1'b1;
        end
      end
      DATA: begin
        if (accept) begin
          shadow_d[8*bcnt_q +: 8] = rx_data_i;
          if (bcnt_q == LAST_BYTE) begin
`ifdef GPR_LOADER_CSUM_EN
            state_d = CSUM;
`else
            state_d = WRITE;
            finish  = 1'b1;
`endif
          end
        end else if (expired) begin
          abort = 1'b1;
        end
      end
`ifdef GPR_LOADER_CSUM_EN
      CSUM: begin
        if (accept) begin
          if (rx_data_i == csum_q) begin
            state_d = WRITE;
            finish  = 1'b1;
          end else begin
            abort = 1'b1;
          end
        end else if (expired) begin
          abort = 1'b1;
        end
      end
`endif
      WRITE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort) state_d = IDLE;
  end

  always_ff @(posedge reg_clk or posedge reg_rst) begin
    if (reg_rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Outputs are registered on the accepting edge so the strobe lands in the WRITE cycle.
  always_ff @(posedge reg_clk or posedge reg_rst) begin
    if (reg_rst) begin
      bcnt_q        <= '0;
      idx_q         <= '0;
      shadow_q      <= '0;
      uart_rd       <= '0;
      uart_data     <= '0;
      uart_rd_valid <= 1'b0;
      frame_err_o   <= 1'b0;
      load_cnt_o    <= 8'd0;
`ifdef GPR_LOADER_CSUM_EN
      csum_q        <= 8'd0;
`endif
    end else begin
      uart_rd_valid <= 1'b0;
      frame_err_o   <= abort || (finish && (idx_q == '0));
      shadow_q      <= shadow_d;
      if (accept && (state_q == IDX)) begin
        idx_q  <= rx_data_i[GPR_ADDR_WIDTH-1:0];
        bcnt_q <= '0;
`ifdef GPR_LOADER_CSUM_EN
        csum_q <= rx_data_i;
`endif
      end
      if (accept && (state_q == DATA)) begin
        bcnt_q <= bcnt_q + 1'b1;
`ifdef GPR_LOADER_CSUM_EN
        csum_q <= csum_q ^ rx_data_i;
`endif
      end
      if (finish && (idx_q != '0)) begin
        uart_rd       <= idx_q;
        uart_data     <= shadow_d;
        uart_rd_valid <= 1'b1;
        if (load_cnt_o != 8'hFF) load_cnt_o <= load_cnt_o + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_gpr_uart_loader.sv
// Directed bench for gpr_uart_loader: a frame-level model tracks expected outputs every
// cycle, and literal checks pin key results. Honors GPR_LOADER_CSUM_EN.
module tb_gpr_uart_loader;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int T  = 16;
  localparam int NB = DW / 8;
`ifdef GPR_LOADER_CSUM_EN
  localparam int FL = 2 + NB + 1;
`else
  localparam int FL = 2 + NB;
`endif

  logic          reg_clk = 1'b0;
  logic          reg_rst = 1'b1;
  logic [7:0]    rx_data_i = 8'd0;
  logic          rx_valid_i = 1'b0;
  logic          rx_ready_o;
  logic [AW-1:0] uart_rd;
  logic          uart_rd_valid;
  logic [DW-1:0] uart_data;
  logic          busy_o;
  logic          frame_err_o;
  logic [7:0]    load_cnt_o;

  gpr_uart_loader #(
    .DATA_WIDTH(DW), .GPR_ADDR_WIDTH(AW), .FRAME_HDR(8'hA5), .TIMEOUT_CYCLES(T)
  ) dut (
    .reg_clk(reg_clk), .reg_rst(reg_rst), .rx_data_i(rx_data_i), .rx_valid_i(rx_valid_i),
    .rx_ready_o(rx_ready_o), .uart_rd(uart_rd), .uart_rd_valid(uart_rd_valid),
    .uart_data(uart_data), .busy_o(busy_o), .frame_err_o(frame_err_o), .load_cnt_o(load_cnt_o)
  );

  always #5 reg_clk = ~reg_clk;

  int n_total = 0;
  int n_pass  = 0;
  int n_wr    = 0;
  int n_err   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
  endtask

  // Frame-level reference: bytes of the current frame, idle gap, pending write cycle.
  logic [7:0]    m_q[$];
  int            m_gap;
  bit            m_wr;
  logic          e_valid, e_err;
  logic [AW-1:0] e_rd;
  logic [DW-1:0] e_data;
  logic [7:0]    e_cnt;

  task complete_frame();
    logic [7:0]    x;
    logic [DW-1:0] d;
    x = 8'd0;
    d = '0;
    for (int k = 0; k < NB; k++) d = d | (DW'(m_q[2+k]) << (8*k));
    for (int k = 1; k < 2 + NB; k++) x = x ^ m_q[k];
`ifdef GPR_LOADER_CSUM_EN
    if (x != m_q[FL-1]) begin
      e_err = 1'b1;
      m_q.delete();
      return;
    end
`endif
    m_wr = 1'b1;
    if (m_q[1] == 8'd0) begin
      e_err = 1'b1;
    end else begin
      e_valid = 1'b1;
      e_rd    = m_q[1][AW-1:0];
      e_data  = d;
      if (e_cnt < 8'd255) e_cnt = e_cnt + 8'd1;
    end
    m_q.delete();
  endtask

  always @(posedge reg_clk or posedge reg_rst) begin
    if (reg_rst) begin
      m_q.delete();
      m_gap = 0; m_wr = 1'b0;
      e_valid = 1'b0; e_err = 1'b0; e_rd = '0; e_data = '0; e_cnt = 8'd0;
    end else begin
      bit acc;
      acc = rx_valid_i && !m_wr;
      e_valid = 1'b0;
      e_err   = 1'b0;
      if (m_wr) begin
        m_wr = 1'b0;
      end else if (m_q.size() == 0) begin
        if (acc && rx_data_i == 8'hA5) begin
          m_q.push_back(rx_data_i);
          m_gap = 0;
        end
      end else if (acc) begin
        m_q.push_back(rx_data_i);
        m_gap = 0;
        if (m_q.size() == 2 && rx_data_i >= (8'd1 << AW)) begin
          e_err = 1'b1;
          m_q.delete();
        end else if (m_q.size() == FL) begin
          complete_frame();
        end
      end else if (m_gap == T - 1) begin
        e_err = 1'b1;
        m_q.delete();
      end else begin
        m_gap++;
      end
    end
  end

  always @(negedge reg_clk) begin
    if (uart_rd_valid) n_wr++;
    if (frame_err_o) n_err++;
    check("rx_ready_o", rx_ready_o, !m_wr);
    check("busy_o", busy_o, (m_q.size() != 0) || m_wr);
    check("uart_rd_valid", uart_rd_valid, e_valid);
    check("frame_err_o", frame_err_o, e_err);
    check("uart_rd", uart_rd, e_rd);
    check("uart_data", uart_data, e_data);
    check("load_cnt_o", load_cnt_o, e_cnt);
  end

  task automatic send_byte(input logic [7:0] b);
    bit done;
    done = 1'b0;
    rx_valid_i = 1'b1;
    rx_data_i  = b;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge reg_clk);
      done = rx_ready_o;
      @(posedge reg_clk);
    end
    if (!done) check("send_timeout", 0, 1);
    #1;
    rx_valid_i = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] idx, input logic [31:0] d);
    logic [7:0] x;
    x = idx;
    send_byte(8'hA5);
    send_byte(idx);
    for (int k = 0; k < NB; k++) begin
      send_byte(d[8*k +: 8]);
      x = x ^ d[8*k +: 8];
    end
`ifdef GPR_LOADER_CSUM_EN
    send_byte(x);
`endif
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge reg_clk);
    #1;
  endtask

  int w0, e0;

  initial begin
    repeat (3) @(posedge reg_clk);
    #1;
    check("rst_ready", rx_ready_o, 1);
    check("rst_rd", uart_rd, 0);
    check("rst_data", uart_data, 0);
    check("rst_cnt", load_cnt_o, 0);
    reg_rst = 1'b0;
    idle(2);

    // Basic frame: strobe visible the cycle after the last data byte.
    w0 = n_wr;
    send_frame(8'h03, 32'h12345678);
    check("t1_valid", uart_rd_valid, 1);
    check("t1_rd", uart_rd, 3);
    check("t1_data", uart_data, 32'h12345678);
    check("t1_cnt", load_cnt_o, 1);
    idle(1);
    check("t1_valid_low", uart_rd_valid, 0);
    idle(2);
    check("t1_writes", n_wr - w0, 1);

    // Leading junk is dropped silently.
    w0 = n_wr; e0 = n_err;
    send_byte(8'h00);
    send_byte(8'hFF);
    send_frame(8'h05, 32'h04030201);
    idle(3);
    check("t2_err", n_err - e0, 0);
    check("t2_writes", n_wr - w0, 1);
    check("t2_rd", uart_rd, 5);
    check("t2_data", uart_data, 32'h04030201);

    // Index 0 suppressed; out-of-range index aborts right after the index byte.
    w0 = n_wr; e0 = n_err;
    send_frame(8'h00, 32'h44332211);
    idle(3);
    check("t3_writes", n_wr - w0, 0);
    check("t3_err", n_err - e0, 1);
    check("t3_cnt", load_cnt_o, 2);
    send_byte(8'hA5);
    send_byte(8'h25);
    check("t3_bad_idx_err", frame_err_o, 1);
    check("t3_bad_idx_busy", busy_o, 0);
    idle(3);

    // Idle gap of T cycles aborts the frame.
    send_byte(8'hA5);
    send_byte(8'h07);
    send_byte(8'hAA);
    repeat (T) @(posedge reg_clk);
    #1;
    check("t4_timeout_err", frame_err_o, 1);
    check("t4_timeout_busy", busy_o, 0);
    idle(2);
    send_frame(8'h07, 32'hAABBCCDD);
    idle(2);
    check("t4_rd", uart_rd, 7);
    check("t4_data", uart_data, 32'hAABBCCDD);

    // Byte landing on the threshold cycle keeps the frame alive.
    e0 = n_err; w0 = n_wr;
    send_byte(8'hA5);
    send_byte(8'h07);
    send_byte(8'h11);
    repeat (T - 1) @(posedge reg_clk);
    #1;
    send_byte(8'h22);
    send_byte(8'h33);
    send_byte(8'h44);
`ifdef GPR_LOADER_CSUM_EN
    send_byte(8'h07 ^ 8'h11 ^ 8'h22 ^ 8'h33 ^ 8'h44);
`endif
    idle(3);
    check("t4_thr_err", n_err - e0, 0);
    check("t4_thr_writes", n_wr - w0, 1);
    check("t4_thr_data", uart_data, 32'h44332211);

    // Reset mid-frame.
    w0 = n_wr;
    send_byte(8'hA5);
    send_byte(8'h09);
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h03);
    #2 reg_rst = 1'b1;
    #1;
    check("t5_rst_valid", uart_rd_valid, 0);
    check("t5_rst_busy", busy_o, 0);
    check("t5_rst_ready", rx_ready_o, 1);
    check("t5_rst_rd", uart_rd, 0);
    check("t5_rst_data", uart_data, 0);
    check("t5_rst_cnt", load_cnt_o, 0);
    @(posedge reg_clk);
    #1 reg_rst = 1'b0;
    idle(1);
    send_frame(8'h0A, 32'h00000001);
    idle(2);
    check("t5_writes", n_wr - w0, 1);
    check("t5_rd", uart_rd, 10);
    check("t5_data", uart_data, 1);
    check("t5_cnt", load_cnt_o, 1);

    // Saturation of the success counter.
    for (int i = 0; i < 256; i++) send_frame(8'((i % 31) + 1), 32'(i));
    idle(2);
    check("t6_cnt_sat", load_cnt_o, 255);
    check("t6_rd", uart_rd, 8'((255 % 31) + 1));
    check("t6_data", uart_data, 255);

`ifdef GPR_LOADER_CSUM_EN
    w0 = n_wr; e0 = n_err;
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h01);
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h00);
    idle(2);
    check("c1_writes", n_wr - w0, 1);
    check("c1_rd", uart_rd, 1);
    check("c1_data", uart_data, 1);
    w0 = n_wr;
    send_byte(8'hA5); send_byte(8'h01); send_byte(8'h01);
    send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'h5A);
    check("c2_err", frame_err_o, 1);
    idle(2);
    check("c2_writes", n_wr - w0, 0);
    check("c2_err_cnt", n_err - e0, 1);
`endif

    idle(2);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
